// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among NUM_REQ pixel fetchers.
// A tag pipeline follows each granted read so the returning word is steered to its owner.
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 24,
    parameter int ROM_LATENCY = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*ADDR_W-1:0] Addr,
    output logic [NUM_REQ-1:0]        Gnt,
    output logic                      RomRdEn,
    output logic [ADDR_W-1:0]         RomAddr,
    input  logic [DATA_W-1:0]         RomData,
    output logic [NUM_REQ-1:0]        RdValid,
    output logic [DATA_W-1:0]         RdData,
    output logic                      Busy
);

    localparam int              ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (id == ID_W'(i));
        end
        return v;
    endfunction

    logic [ID_W-1:0]    ptr_q, ptr_d, ptr_eff;
    logic               hit_hi, hit_lo, gnt_any;
    logic [ID_W-1:0]    win_hi, win_lo, win_id;
    logic [ADDR_W-1:0]  addr_hi, addr_lo;

    logic [ROM_LATENCY:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]      tag_id_q [0:ROM_LATENCY];
    logic [ID_W-1:0]      tag_id_d [0:ROM_LATENCY];

    logic [NUM_REQ-1:0]   rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;

    // Arbitration: the "hi" pass finds the first requester at or above the pointer,
    // the "lo" pass the first one overall, which is the winner after wrapping.
    always_comb begin
        ptr_eff = ({1'b0, ptr_q} >= NUM_REQ_W) ? '0 : ptr_q;
        hit_hi  = 1'b0;
        hit_lo  = 1'b0;
        win_hi  = '0;
        win_lo  = '0;
        addr_hi = '0;
        addr_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Req[i]) begin
                if (ID_W'(i) >= ptr_eff) begin
                    hit_hi  = 1'b1;
                    win_hi  = ID_W'(i);
                    addr_hi = Addr[i*ADDR_W +: ADDR_W];
                end
                hit_lo  = 1'b1;
                win_lo  = ID_W'(i);
                addr_lo = Addr[i*ADDR_W +: ADDR_W];
            end
        end

        gnt_any = hit_hi | hit_lo;
        win_id  = hit_hi ? win_hi : win_lo;
        Gnt     = gnt_any ? onehot(win_id) : '0;
        RomRdEn = gnt_any;
        RomAddr = gnt_any ? (hit_hi ? addr_hi : addr_lo) : '0;

        if (gnt_any) begin
            ptr_d = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
        end else begin
            ptr_d = ptr_eff;
        end
    end

    // Tag pipeline: stage ROM_LATENCY-1 lines up with the cycle RomData is valid.
    always_comb begin
        tag_vld_d   = {tag_vld_q[ROM_LATENCY-1:0], RomRdEn};
        tag_id_d[0] = win_id;
        for (int k = 1; k <= ROM_LATENCY; k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end

        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (tag_vld_q[ROM_LATENCY-1]) begin
            rd_valid_d = onehot(tag_id_q[ROM_LATENCY-1]);
            rd_data_d  = RomData;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q      <= '0;
            tag_vld_q  <= '0;
            for (int k = 0; k <= ROM_LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tag_vld_q  <= tag_vld_d;
            for (int k = 0; k <= ROM_LATENCY; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign RdValid = rd_valid_q;
    assign RdData  = rd_data_q;
    assign Busy    = |tag_vld_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 2-cycle synchronous ROM model.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 24;

    logic                      Clk = 1'b0;
    logic                      Reset = 1'b1;
    logic [NUM_REQ-1:0]        Req = '0;
    logic [NUM_REQ*ADDR_W-1:0] Addr = '0;
    logic [NUM_REQ-1:0]        Gnt;
    logic                      RomRdEn;
    logic [ADDR_W-1:0]         RomAddr;
    logic [DATA_W-1:0]         RomData;
    logic [NUM_REQ-1:0]        RdValid;
    logic [DATA_W-1:0]         RdData;
    logic                      Busy;

    int checks = 0;
    int errors = 0;

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .Gnt(Gnt),
        .RomRdEn(RomRdEn), .RomAddr(RomAddr), .RomData(RomData),
        .RdValid(RdValid), .RdData(RdData), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // ROM contents: 0x0123 holds 0xABCDEF, every other word is {9'h1A5, addr}
    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return (a == 15'h0123) ? 24'hABCDEF : {9'h1A5, a};
    endfunction

    logic [DATA_W-1:0] rom_s1 = '0, rom_s2 = '0;
    always @(posedge Clk) begin
        rom_s1 <= RomRdEn ? rom_f(RomAddr) : 24'h000000;
        rom_s2 <= rom_s1;
    end
    assign RomData = rom_s2;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        Addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset;
        Req   = '0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if ({Gnt, RomRdEn, RdValid, Busy} !== 8'b0) begin
                errors++;
                $display("FAIL reset_idle c=%0d got gnt=%b en=%b rdv=%b busy=%b exp all 0", c, Gnt, RomRdEn, RdValid, Busy);
            end
            checks++;
            if (RomAddr !== 15'h0 || RdData !== 24'h0) begin
                errors++;
                $display("FAIL reset_regs c=%0d got addr=%h data=%h exp 0 0", c, RomAddr, RdData);
            end
            tick();
        end
    endtask

    task automatic test_single;
        Req = 3'b001;
        set_addr(0, 15'h0123);
        #1;
        checks++;
        if (Gnt !== 3'b001 || RomRdEn !== 1'b1 || RomAddr !== 15'h0123) begin
            errors++;
            $display("FAIL single_grant got gnt=%b en=%b addr=%h exp 001 1 0123", Gnt, RomRdEn, RomAddr);
        end
        tick();
        Req = '0;
        #1;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy got %b exp 1", Busy);
        end
        tick();
        tick();
        checks++;
        if (RdValid !== 3'b001 || RdData !== 24'hABCDEF) begin
            errors++;
            $display("FAIL single_return got rdv=%b data=%h exp 001 abcdef", RdValid, RdData);
        end
        tick();
        checks++;
        if (RdValid !== 3'b000 || RdData !== 24'hABCDEF) begin
            errors++;
            $display("FAIL single_hold got rdv=%b data=%h exp 000 abcdef", RdValid, RdData);
        end
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%b exp 0", Busy);
        end
    endtask

    task automatic test_rotation;
        logic [NUM_REQ-1:0] exp_g;
        logic [ADDR_W-1:0]  exp_a;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            Req = (k < 9) ? 3'b111 : 3'b000;
            for (int i = 0; i < NUM_REQ; i++) set_addr(i, ADDR_W'((i << 12) | k));
            #1;
            exp_g = (k < 9) ? 3'(1 << (k % 3)) : 3'b000;
            exp_a = (k < 9) ? ADDR_W'(((k % 3) << 12) | k) : 15'h0;
            checks++;
            if (Gnt !== exp_g || RomAddr !== exp_a) begin
                errors++;
                $display("FAIL rot_grant k=%0d got gnt=%b addr=%h exp %b %h", k, Gnt, RomAddr, exp_g, exp_a);
            end
            if (k >= 3) begin
                exp_g = 3'(1 << ((k - 3) % 3));
                exp_a = ADDR_W'((((k - 3) % 3) << 12) | (k - 3));
                checks++;
                if (RdValid !== exp_g || RdData !== rom_f(exp_a)) begin
                    errors++;
                    $display("FAIL rot_return k=%0d got rdv=%b data=%h exp %b %h", k, RdValid, RdData, exp_g, rom_f(exp_a));
                end
            end else begin
                checks++;
                if (RdValid !== 3'b000) begin
                    errors++;
                    $display("FAIL rot_early k=%0d got rdv=%b exp 000", k, RdValid);
                end
            end
            tick();
        end
        checks++;
        if (Busy !== 1'b0 || RdValid !== 3'b000) begin
            errors++;
            $display("FAIL rot_drain got busy=%b rdv=%b exp 0 000", Busy, RdValid);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        Req = 3'b010;
        set_addr(0, 15'h0A00);
        set_addr(1, 15'h0B00);
        #1;
        checks++;
        if (Gnt !== 3'b010 || RomAddr !== 15'h0B00) begin
            errors++;
            $display("FAIL wrap_first got gnt=%b addr=%h exp 010 0b00", Gnt, RomAddr);
        end
        tick();
        Req = 3'b011;
        #1;
        checks++;
        if (Gnt !== 3'b001 || RomAddr !== 15'h0A00) begin
            errors++;
            $display("FAIL wrap_to0 got gnt=%b addr=%h exp 001 0a00", Gnt, RomAddr);
        end
        tick();
        Req = 3'b010;
        #1;
        checks++;
        if (Gnt !== 3'b010) begin
            errors++;
            $display("FAIL wrap_then1 got gnt=%b exp 010", Gnt);
        end
        tick();
        Req = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_withdraw;
        do_reset();
        Req = 3'b011;
        set_addr(0, 15'h0055);
        set_addr(1, 15'h0066);
        #1;
        checks++;
        if (Gnt !== 3'b001 || RomAddr !== 15'h0055) begin
            errors++;
            $display("FAIL wd_grant got gnt=%b addr=%h exp 001 0055", Gnt, RomAddr);
        end
        tick();
        Req = 3'b000;
        #1;
        checks++;
        if (Gnt !== 3'b000 || RomRdEn !== 1'b0) begin
            errors++;
            $display("FAIL wd_nogrant got gnt=%b en=%b exp 000 0", Gnt, RomRdEn);
        end
        for (int c = 2; c < 6; c++) begin
            tick();
            checks++;
            if (RdValid !== ((c == 3) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL wd_return c=%0d got rdv=%b exp %b", c, RdValid, (c == 3) ? 3'b001 : 3'b000);
            end
        end
        tick();
        Req = 3'b011;
        #1;
        checks++;
        if (Gnt !== 3'b010 || RomAddr !== 15'h0066) begin
            errors++;
            $display("FAIL wd_ptr got gnt=%b addr=%h exp 010 0066", Gnt, RomAddr);
        end
        tick();
        Req = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_reset_inflight;
        do_reset();
        Req = 3'b001;
        set_addr(0, 15'h0011);
        set_addr(1, 15'h0022);
        set_addr(2, 15'h0033);
        tick();
        Req = 3'b010;
        tick();
        Req = '0;
        Reset = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || RdValid !== 3'b000) begin
            errors++;
            $display("FAIL rst_flight got busy=%b rdv=%b exp 0 000", Busy, RdValid);
        end
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (Busy !== 1'b0 || RdValid !== 3'b000) begin
                errors++;
                $display("FAIL rst_quiet c=%0d got busy=%b rdv=%b exp 0 000", c, Busy, RdValid);
            end
            tick();
        end
        Req = 3'b110;
        #1;
        checks++;
        if (Gnt !== 3'b010) begin
            errors++;
            $display("FAIL rst_ptr0 got gnt=%b exp 010", Gnt);
        end
        tick();
        Req = 3'b100;
        #1;
        checks++;
        if (Gnt !== 3'b100 || RomAddr !== 15'h0033) begin
            errors++;
            $display("FAIL rst_grant2 got gnt=%b addr=%h exp 100 0033", Gnt, RomAddr);
        end
        tick();
        Req = '0;
        tick();
        checks++;
        if (RdValid !== 3'b010 || RdData !== rom_f(15'h0022)) begin
            errors++;
            $display("FAIL rst_ret1 got rdv=%b data=%h exp 010 %h", RdValid, RdData, rom_f(15'h0022));
        end
        tick();
        checks++;
        if (RdValid !== 3'b100 || RdData !== rom_f(15'h0033)) begin
            errors++;
            $display("FAIL rst_ret2 got rdv=%b data=%h exp 100 %h", RdValid, RdData, rom_f(15'h0033));
        end
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_withdraw();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
